uart_tx_fifo: RTL and testbench

//  Output-side I/O buffer between the cpu memory bus and the UART transmitter.

---
 rtl/uart_tx_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : CPU-to-UART output buffer. Decodes byte writes to the putchar
//                (0x30000) and program-stop (0x30004) addresses, queues them in
//                a show-ahead FIFO, drains it over a valid/ready handshake and
//                returns registered back-pressure to the CPU.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_done,
  output logic        overflow
);

  localparam int                  c_depth     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_depth_cnt = (DEPTH_LOG2 + 1)'(c_depth);
  localparam logic [DEPTH_LOG2:0] c_margin    = (DEPTH_LOG2 + 1)'(FULL_MARGIN);
  localparam logic [DEPTH_LOG2:0] c_cnt_one   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one = DEPTH_LOG2'(1);

  // Storage: data bytes plus a per-entry marker identifying the stop byte
  logic [7:0] mem_q [c_depth];
  logic       tag_q [c_depth];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  halted_q, halted_d;
  logic                  io_full_q, io_full_d;
  logic                  prog_done_q, prog_done_d;
  logic                  overflow_q, overflow_d;

  logic                  w_io_hit;
  logic                  w_put;
  logic                  w_stop;
  logic                  w_push;
  logic                  w_full;
  logic                  w_push_ok;
  logic                  w_pop;
  logic [7:0]            w_wr_data;
  logic [DEPTH_LOG2:0]   w_free_next;

  // Only bits 17:16 and 2 of the address take part in the I/O decode
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_a[31:18], mem_a[15:3], mem_a[1:0]};

  // Bus decode and FIFO handshake qualifiers
  always_comb begin
    w_io_hit  = mem_wr & rdy_in & (mem_a[17:16] == 2'b11);
    w_put     = w_io_hit & ~mem_a[2] & (mem_dout != 8'h00);
    w_stop    = w_io_hit & mem_a[2];
    w_push    = (w_put | w_stop) & ~halted_q;
    w_full    = (count_q == c_depth_cnt);
    // A pop in the same cycle never frees room for a push into a full FIFO
    w_push_ok = w_push & ~w_full;
    w_pop     = tx_valid & tx_ready;
    // The stop marker is always queued as a zero byte
    w_wr_data = w_stop ? 8'h00 : mem_dout;
  end

  // Next-state computation for pointers, occupancy and sticky flags
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    halted_d    = halted_q;
    overflow_d  = overflow_q | (w_push & w_full);
    prog_done_d = prog_done_q | (w_pop & tag_q[rd_ptr_q]);

    if (w_push_ok) begin
      wr_ptr_d = wr_ptr_q + c_ptr_one;
      // A stop that was dropped for lack of room does not halt the bus side
      halted_d = halted_q | w_stop;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end

    case ({w_push_ok, w_pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase

    // Registered back-pressure looks at next occupancy; the margin covers
    // writes the CPU already has in flight during the one-cycle latency
    w_free_next = c_depth_cnt - count_d;
    io_full_d   = (w_free_next <= c_margin);
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      halted_q    <= 1'b0;
      io_full_q   <= 1'b0;
      prog_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      halted_q    <= halted_d;
      io_full_q   <= io_full_d;
      prog_done_q <= prog_done_d;
      overflow_q  <= overflow_d;
    end
  end

  // Entry write; contents need no reset since count gates visibility
  always_ff @(posedge clk_in) begin
    if (!rst_in && w_push_ok) begin
      mem_q[wr_ptr_q] <= w_wr_data;
      tag_q[wr_ptr_q] <= w_stop;
    end
  end

  assign tx_valid       = (count_q != '0);
  assign tx_data        = mem_q[rd_ptr_q];
  assign io_buffer_full = io_full_q;
  assign prog_done      = prog_done_q;
  assign overflow       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo. A queue-level reference
//                model tracks occupancy and flags; accepted bytes go into a
//                scoreboard that a monitor drains on each tx handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int c_depth  = 16;
  localparam int c_margin = 2;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        prog_done;
  logic        overflow;

  uart_tx_fifo #(.DEPTH_LOG2(4), .FULL_MARGIN(c_margin)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .prog_done      (prog_done),
    .overflow       (overflow)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: queue entries are {stop_flag, byte}
  logic [8:0] mq[$];
  logic [7:0] exp_q[$];
  bit         m_halted;
  bit         m_ovf;
  bit         m_done;
  bit         m_full;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted byte must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk_in);
      if (!rst_in && tx_valid === 1'b1 && tx_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          chk("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // Model update from the inputs applied this cycle, before the clock edge
  task automatic model_step(input logic r, input logic rdy, input logic wr,
                            input logic [31:0] a, input logic [7:0] d,
                            input logic txr);
    bit hit, put, stp, push, full, pop;
    if (r) begin
      mq.delete();
      exp_q.delete();
      m_halted = 0;
      m_ovf    = 0;
      m_done   = 0;
      m_full   = 0;
      return;
    end
    hit  = wr && rdy && (a[17:16] == 2'b11);
    put  = hit && !a[2] && (d != 8'h00);
    stp  = hit && a[2];
    push = (put || stp) && !m_halted;
    full = (mq.size() == c_depth);
    pop  = (mq.size() != 0) && txr;
    if (push && full) m_ovf = 1;
    if (pop) begin
      if (mq[0][8]) m_done = 1;
      void'(mq.pop_front());
    end
    if (push && !full) begin
      mq.push_back({stp, stp ? 8'h00 : d});
      exp_q.push_back(stp ? 8'h00 : d);
      if (stp) m_halted = 1;
    end
    m_full = ((c_depth - mq.size()) <= c_margin);
  endtask

  // Apply one cycle of stimulus, advance the model, then check registered state
  task automatic cycle(input logic r, input logic rdy, input logic wr,
                       input logic [31:0] a, input logic [7:0] d,
                       input logic txr);
    rst_in   = r;
    rdy_in   = rdy;
    mem_wr   = wr;
    mem_a    = a;
    mem_dout = d;
    tx_ready = txr;
    model_step(r, rdy, wr, a, d, txr);
    @(posedge clk_in);
    #1;
    chk("tx_valid",       {31'h0, tx_valid},       {31'h0, (mq.size() != 0)});
    chk("io_buffer_full", {31'h0, io_buffer_full}, {31'h0, m_full});
    chk("overflow",       {31'h0, overflow},       {31'h0, m_ovf});
    chk("prog_done",      {31'h0, prog_done},      {31'h0, m_done});
  endtask

  task automatic put_byte(input logic [7:0] d, input logic txr);
    cycle(1'b0, 1'b1, 1'b1, 32'h0003_0000, d, txr);
  endtask

  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 8'h00, txr);
  endtask

  initial begin
    rst_in   = 1'b1;
    rdy_in   = 1'b0;
    mem_wr   = 1'b0;
    mem_a    = 32'h0;
    mem_dout = 8'h00;
    tx_ready = 1'b0;

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);

    // Three bytes streamed out back to back
    put_byte(8'h41, 1'b1);
    put_byte(8'h42, 1'b1);
    put_byte(8'h43, 1'b1);
    idle(4, 1'b1);

    // Zero byte to putchar is ignored
    put_byte(8'h00, 1'b1);
    idle(2, 1'b1);

    // Write while CPU not ready is ignored
    cycle(1'b0, 1'b0, 1'b1, 32'h0003_0000, 8'h55, 1'b1);
    idle(2, 1'b1);

    // Fill with transmitter stalled; pushes 17 and 18 overflow
    for (int i = 0; i < 18; i++) put_byte(8'(i + 1), 1'b0);
    idle(2, 1'b0);

    // Push and pop together while full: push dropped
    put_byte(8'h99, 1'b1);
    idle(20, 1'b1);

    // Reset, then stop sequence: 48, stop, 49 (ignored)
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0);
    put_byte(8'h48, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h0003_0004, 8'hAB, 1'b0);
    put_byte(8'h49, 1'b0);
    idle(2, 1'b0);
    idle(5, 1'b1);

    // Reset mid-drain with five bytes queued
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) put_byte(8'(8'h60 + i), 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 8'h00, 1'b1);
    idle(2, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic        r, rdy, wr, txr;
      logic [31:0] a;
      logic [7:0]  d;
      int          sel;
      r   = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 9) < 8);
      wr  = ($urandom_range(0, 9) < 6);
      txr = ($urandom_range(0, 9) < ((n / 300) % 2 == 0 ? 3 : 8));
      sel = $urandom_range(0, 99);
      if (sel < 70)      a = 32'h0003_0000;
      else if (sel < 73) a = 32'h0003_0004;
      else if (sel < 80) a = 32'h0003_0008;
      else if (sel < 90) a = 32'h0002_0000;
      else               a = $urandom;
      d = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      cycle(r, rdy, wr, a, d, txr);
    end

    // Final drain: everything accepted must have been transmitted
    idle(c_depth + 4, 1'b1);
    @(negedge clk_in);
    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
